// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared types and constants for the instruction-fetch controller.
//   - fetch_entry_t : one decode-side buffer entry (pc, instruction, misalign flag)
//   - fetch_state_t : fetch controller state (IDLE, REQ, DRAIN, HALT)
//   - DEFAULT_RESET_PC / FETCH_FIFO_DEPTH : parameter defaults for fetch_ctrl
package fetch_ctrl_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Instructions are 32-bit aligned; any low PC bit set is an
  // instruction-address-misaligned fault.
  function automatic logic pc_misaligned(input logic [63:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// fetch_fifo
//   Two-entry FIFO of fetch_entry_t between the fetch controller and decode.
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     push        : write push_entry at the tail
//     push_entry  : entry to write
//     pop         : drop the head entry (ignored when empty)
//     flush       : empty the FIFO; wins over push and pop
//     head_entry  : current head entry, all-zero when empty
//     count       : number of valid entries (0..2)
module fetch_fifo
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_entry,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         head_q;
  logic [1:0]   count_q;
  logic         wr_idx;
  logic         do_pop;
  logic         do_push;

  // Qualify the requests: no pop from an empty FIFO, and a push into a full
  // FIFO is only legal when the head is leaving in the same cycle.
  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // Tail slot sits count entries past the head. With two slots, a full FIFO
  // wraps the tail onto the head slot, which is exactly the slot being freed
  // by the simultaneous pop.
  assign wr_idx = head_q ^ count_q[0];

  // Storage, head pointer and occupancy. A flush only rewinds the pointers;
  // the stale slot contents are hidden by the zero-when-empty head output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_entry;
      end
      if (do_pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_entry = (count_q != 2'd0) ? mem[head_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch controller in front of the fetch MMU. Owns the fetch PC,
//   issues one MMU request at a time, buffers up to two fetched instructions
//   for decode and handles redirects, including discarding a stale in-flight
//   response.
//   Ports:
//     clk, rst_n      : clock (rising edge), asynchronous active-low reset
//     redirect_valid  : flush and restart fetch at redirect_pc
//     redirect_pc     : new fetch PC
//     fetch_req       : request to the fetch MMU (registered)
//     fetch_pc        : virtual PC of the request (registered, 0 when idle)
//     mmu_ok          : one-cycle completion pulse from the MMU
//     mmu_data        : instruction returned with mmu_ok
//     f_valid         : decode head entry valid
//     f_ready         : decode accepts the head entry
//     f_pc            : PC of the head entry
//     f_instr         : instruction of the head entry
//     f_misalign      : head entry is an instruction-address-misaligned fault
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
  // Only a depth of 2 is supported; the FIFO is built for exactly two slots.
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_req,
  output logic [63:0] fetch_pc,
  input  logic        mmu_ok,
  input  logic [31:0] mmu_data,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_misalign
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [63:0]  pc_q;
  logic [63:0]  pc_d;
  logic [63:0]  stale_pc_q;
  logic [63:0]  stale_pc_d;
  logic         req_d;
  logic [63:0]  req_pc_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [1:0]   fifo_count;
  logic [1:0]   count_after_pop;
  logic [1:0]   count_after_push;

  assign f_valid = (fifo_count != 2'd0);

  // Next-state logic. Redirect has top priority: it flushes the buffer, voids
  // any pop in the same cycle and reloads the PC. A request already on the
  // bus cannot be withdrawn, so a redirect that arrives before its mmu_ok
  // parks the FSM in DRAIN until that stale response has been swallowed.
  // The request decision looks at the occupancy after this cycle's pop so a
  // slot freed by decode can be refilled without a bubble, and a request is
  // only ever issued into a free slot so the completing push cannot overflow.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    stale_pc_d       = stale_pc_q;
    fifo_push        = 1'b0;
    push_entry       = '0;
    fifo_flush       = redirect_valid;
    fifo_pop         = f_valid && f_ready && !redirect_valid;
    count_after_pop  = fifo_count - {1'b0, fifo_pop};
    count_after_push = count_after_pop;

    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (count_after_pop < DEPTH) begin
          if (pc_misaligned(pc_q)) begin
            // Report the fault once through the buffer, then stop fetching.
            fifo_push           = 1'b1;
            push_entry.pc       = pc_q;
            push_entry.instr    = 32'h0;
            push_entry.misalign = 1'b1;
            state_d             = HALT;
          end else begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mmu_ok) begin
            // Response lands on the redirect edge: drop it, nothing pending.
            state_d = IDLE;
          end else begin
            stale_pc_d = pc_q;
            state_d    = DRAIN;
          end
        end else if (mmu_ok) begin
          fifo_push           = 1'b1;
          push_entry.pc       = pc_q;
          push_entry.instr    = mmu_data;
          push_entry.misalign = 1'b0;
          pc_d                = pc_q + 64'd4;
          count_after_push    = count_after_pop + 2'd1;
          state_d             = (count_after_push < DEPTH) ? REQ : IDLE;
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        // The stale response ends the drain even when a further redirect
        // arrives on the same edge; waiting on would never see another ok.
        if (mmu_ok) begin
          state_d = IDLE;
        end
      end

      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d    = (state_d == REQ) || (state_d == DRAIN);
    req_pc_d = (state_d == REQ)   ? pc_d :
               (state_d == DRAIN) ? stale_pc_d : 64'h0;
  end

  // State, PC and the registered MMU request outputs. The request outputs are
  // computed from the next state so they line up with the state register and
  // stay put for as long as the FSM waits in REQ or DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      stale_pc_q <= 64'h0;
      fetch_req  <= 1'b0;
      fetch_pc   <= 64'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stale_pc_q <= stale_pc_d;
      fetch_req  <= req_d;
      fetch_pc   <= req_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head_entry (head_entry),
    .count      (fifo_count)
  );

  assign f_pc       = head_entry.pc;
  assign f_instr    = head_entry.instr;
  assign f_misalign = head_entry.misalign;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller sitting directly upstream of the fetch MMU.
- Owns the architectural fetch PC and presents one request at a time (fetch_req/fetch_pc) to the MMU.
- Collects the 32-bit instruction returned on mmu_ok and buffers up to two fetched instructions for decode behind a valid/ready handshake.
- Handles redirects (branch/trap) by flushing, including discarding a stale in-flight bus response.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded at reset.
- FIFO_DEPTH, 2, decode-side buffer entries (only 2 is supported).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch PC
- fetch_req  out  1  request to fetch MMU
- fetch_pc  out  64  virtual PC of the request
- mmu_ok  in  1  one-cycle pulse: request complete
- mmu_data  in  32  instruction, valid with mmu_ok
- f_valid  out  1  decode entry valid
- f_ready  in  1  decode accepts entry
- f_pc  out  64  PC of head entry
- f_instr  out  32  instruction of head entry
- f_misalign  out  1  head entry is an instruction-address-misaligned fault

Behaviour:
- Reset (rst_n low, async): state IDLE, pc_q=RESET_PC, FIFO count=0. All outputs 0 immediately: fetch_req, fetch_pc, f_valid, f_pc, f_instr, f_misalign.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DRAIN: stale request outstanding, its response is to be discarded.
  - HALT: misaligned PC, no fetching until redirect.
- IDLE -> REQ when count_after_pop<2 and pc_q[1:0]==0. fetch_req rises in the following cycle.
  - If pc_q[1:0]!=0: push {pc_q, 32'h0, misalign=1} and go to HALT.
- REQ: fetch_req=1, fetch_pc=pc_q. Both are held stable until mmu_ok.
  - On mmu_ok: push {pc_q, mmu_data, 0}, pc_q+=4 (64-bit wrap).
  - Then go to REQ back-to-back if count after this cycle's push/pop is <2, else IDLE.
  - The request is only issued when a slot is free, so a push never overflows.
- DRAIN: fetch_req=1, fetch_pc=old PC held in a separate stale register. On mmu_ok: discard mmu_data, go to IDLE.
- mmu_ok while fetch_req=0 is ignored.
- FIFO:
  - f_valid = count!=0; f_* show the head entry.
  - Pop on f_valid&&f_ready.
  - Push and pop may occur in the same cycle.
  - Head fields are held stable while f_valid&&!f_ready.
- Redirect (highest priority, applied at the clock edge):
  - FIFO count->0; any same-cycle pop is void.
  - pc_q<=redirect_pc.
  - REQ without mmu_ok -> DRAIN.
  - REQ with same-cycle mmu_ok -> data discarded, -> IDLE.
  - DRAIN -> stays DRAIN (pc_q updated).
  - IDLE/HALT -> IDLE.
- Latency: mmu_ok at cycle N -> f_valid at N+1. With an empty FIFO, the next fetch_req starts at N+1 with pc+4.
- A redirect to a misaligned PC yields exactly one f_misalign entry, then HALT.

Decomposition:
- Package common: fetch_entry_t {u64 pc; u32 instr; logic misalign}; fetch_state_t enum {IDLE, REQ, DRAIN, HALT}; localparam RESET_PC default.
- Sub-module fetch_fifo: 2-entry FIFO of fetch_entry_t with push/pop/flush/count. It uses the same async active-low reset.

Test Plan:
- Reset release -> first-cycle fetch_req=1, fetch_pc=0x80000000. mmu_ok after 3 cycles with data 0x00000013 -> next cycle f_valid=1, f_pc=0x80000000, f_instr=0x13; fetch_pc=0x80000004.
- f_ready=0, mmu_ok every cycle -> entries 0x80000000 and 0x80000004 buffered, fetch_req=0, f_pc held. Then f_ready=1 -> drains in order, fetch resumes at 0x80000008.
- Redirect to 0x80001000 while REQ with no ok -> fetch_pc stays 0x80000000 until ok, data discarded, f_valid=0. Next request has fetch_pc=0x80001000.
- Redirect same cycle as mmu_ok -> data dropped, FIFO empty. Fetch_req resumes with fetch_pc=0x80001000 one cycle later.
- Redirect to 0x80000002 -> no fetch_req. f_valid=1, f_misalign=1, f_pc=0x80000002; stays idle until a redirect to 0x80000100 -> fetch_req with 0x80000100.
- rst_n low mid-REQ between clock edges -> fetch_req, f_valid = 0 immediately without a clock edge. After release, restart at 0x80000000.
